conv_mac_sequencer: RTL
=======================

Name: conv_mac_sequencer

Overview:
Upstream/downstream control stage around the 8-bit Booth multiplier in the linear convolution datapath. It stores input sequence x[0..LX-1] and kernel h[0..LH-1], then computes y[n] = sum over k of x[k]*h[n-k] for n = 0..LX+LH-2. It issues one operand pair at a time to the multiplier through a start/done handshake, accumulates signed products, and streams y samples out under valid/ready.

Parameters:
LX, 4, length of x sequence (>=1)
LH, 4, length of h sequence (>=1)
DW, 8, operand width, signed
PW, 16, product width from multiplier, signed
ACC_W, 18, accumulator/output width, signed; must be >= PW + clog2(min(LX,LH))

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
load_x  in  1  write load_data into x[load_idx] (idle only)
load_h  in  1  write load_data into h[load_idx] (idle only)
load_idx  in  clog2(max(LX,LH))  load address
load_data  in  DW  signed sample
start  in  1  begin convolution (idle only)
busy  out  1  high from accepted start until last y accepted
done  out  1  one-cycle pulse after final y handshake
mul_start  out  1  one-cycle request to multiplier
mul_a  out  DW  x operand, held stable from mul_start until mul_done
mul_b  out  DW  h operand, held stable from mul_start until mul_done
mul_done  in  1  one-cycle pulse, mul_prod valid
mul_prod  in  PW  signed product
y_data  out  ACC_W  signed output sample
y_idx  out  clog2(LX+LH-1)  index n of y_data
y_valid  out  1  y_data valid
y_ready  in  1  downstream accept

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: all outputs 0; x, h arrays cleared to 0; state IDLE; acc 0.
- States: IDLE, SETUP, ISSUE, WAIT, NEXT, OUT, FIN.
- IDLE: loads accepted (load_x priority over load_h if both high; out-of-range load_idx ignored). start -> SETUP, n=0, busy=1 next cycle.
- SETUP (1 cycle): acc=0; k_lo=max(0,n-LH+1), k_hi=min(n,LX-1); k=k_lo.
- ISSUE (1 cycle): drive mul_a=x[k], mul_b=h[n-k], pulse mul_start -> WAIT.
- WAIT: hold operands; on mul_done acc += sign-extend(mul_prod) -> NEXT. mul_done outside WAIT ignored. No timeout.
- NEXT: k<k_hi -> k++, ISSUE; else -> OUT.
- OUT: y_valid=1, y_data=acc, y_idx=n, held stable until y_ready. On handshake: n<LX+LH-2 -> n++, SETUP; else -> FIN.
- FIN: done pulse one cycle, busy=0 -> IDLE.
- Total multiplies = LX*LH. Latency per y = 2 + terms*(2+mul latency) + 1 + stall cycles.
- start, load_x, load_h while busy: ignored, arrays unchanged.
- Accumulation wraps modulo 2^ACC_W (cannot overflow with legal ACC_W).
- Reset mid-operation: immediate return to IDLE, mul_start/y_valid drop asynchronously, pending mul_done after reset ignored.

Optional Feature:
ZERO_SKIP_EN: when defined, in ISSUE if x[k]==0 or h[n-k]==0 no mul_start is issued, acc unchanged, go directly to NEXT (saves multiplier cycles). Undefined: every pair issued regardless of value. y results identical either way.

Decomposition:
- Package conv_pkg: state enum, index-width localparams (clog2 of LX, LH, LX+LH-1), sign-extend helper function.
- Sub-module conv_acc: signed ACC_W accumulator with sync clear and add-enable, async active-low reset.

Test Plan:
- x={1,2,3,4}, h={1,1,1,1}, y_ready=1 -> y_idx 0..6 = 1,3,6,10,9,7,4; done pulses once; 16 mul_start pulses.
- x=h={-128,-128,-128,-128} -> y[3]=65536, y[0]=16384, y[6]=16384, no wrap in 18 bits.
- y_ready low 5 cycles while y_idx=2 valid -> y_data=6, y_idx stable, no mul_start during stall.
- start and load_x pulsed during busy (x[0]<=9) -> results unchanged from first scenario, x[0] still 1 afterwards.
- rst_n low while in WAIT at n=3 -> outputs 0 immediately; after release, reload and start -> correct full sequence.
- h={0,0,0,5}, x={1,2,3,4}: ZERO_SKIP_EN defined -> 4 mul_start pulses; undefined -> 16; both yield y=0,0,0,5,10,15,20.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution MAC sequencer.
// Optional build macro ZERO_SKIP_EN is consumed by conv_mac_sequencer.
package conv_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StIssue,
        StWait,
        StNext,
        StOut,
        StFin
    } state_e;

    // Index width that stays legal for a depth of one.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DefLx   = 4;
    localparam int unsigned DefLh   = 4;
    localparam int unsigned DefDw   = 8;
    localparam int unsigned DefPw   = 16;
    localparam int unsigned DefAccW = 18;

    localparam int unsigned XIdxW = idx_w(DefLx);
    localparam int unsigned HIdxW = idx_w(DefLh);
    localparam int unsigned YIdxW = idx_w(DefLx + DefLh - 1);

    // Sign-extend the low w bits of v to 64 bits.
    function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned w);
        logic [63:0] m;
        m = ~64'd0 << w;
        return v[w-1] ? (v | m) : (v & ~m);
    endfunction

endpackage

// File: rtl/conv_mac_sequencer_if.sv
// Load, multiplier and output-stream signals of the convolution MAC sequencer.
interface conv_mac_sequencer_if
    import conv_pkg::*;
#(
    parameter int unsigned LX    = DefLx,
    parameter int unsigned LH    = DefLh,
    parameter int unsigned DW    = DefDw,
    parameter int unsigned PW    = DefPw,
    parameter int unsigned ACC_W = DefAccW
);
    localparam int unsigned LdW = idx_w((LX > LH) ? LX : LH);
    localparam int unsigned YW  = idx_w(LX + LH - 1);

    logic                    load_x;
    logic                    load_h;
    logic [LdW-1:0]          load_idx;
    logic signed [DW-1:0]    load_data;
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    mul_start;
    logic signed [DW-1:0]    mul_a;
    logic signed [DW-1:0]    mul_b;
    logic                    mul_done;
    logic signed [PW-1:0]    mul_prod;
    logic signed [ACC_W-1:0] y_data;
    logic [YW-1:0]           y_idx;
    logic                    y_valid;
    logic                    y_ready;

    modport slave (
        input  load_x, load_h, load_idx, load_data, start, mul_done, mul_prod, y_ready,
        output busy, done, mul_start, mul_a, mul_b, y_data, y_idx, y_valid
    );

    modport master (
        output load_x, load_h, load_idx, load_data, start, mul_done, mul_prod, y_ready,
        input  busy, done, mul_start, mul_a, mul_b, y_data, y_idx, y_valid
    );

endinterface

// File: rtl/conv_acc.sv
// Signed accumulator with synchronous clear and add-enable; wraps modulo 2^ACC_W.
module conv_acc #(
    parameter int unsigned ACC_W = 18
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_i,
    input  logic                    add_i,
    input  logic signed [ACC_W-1:0] addend_i,
    output logic signed [ACC_W-1:0] acc_o
);
    logic signed [ACC_W-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (add_i) begin
            acc_d = acc_q + addend_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/conv_mac_sequencer.sv
// Linear-convolution sequencer: one multiply per x/h pair, y streamed under valid/ready.
// Define ZERO_SKIP_EN to bypass the multiplier when either operand is zero.
module conv_mac_sequencer
    import conv_pkg::*;
#(
    parameter int unsigned LX    = DefLx,
    parameter int unsigned LH    = DefLh,
    parameter int unsigned DW    = DefDw,
    parameter int unsigned PW    = DefPw,
    parameter int unsigned ACC_W = DefAccW
) (
    input logic                 clk,
    input logic                 rst_n,
    conv_mac_sequencer_if.slave bus
);
    localparam int unsigned KW    = idx_w(LX);
    localparam int unsigned HW    = idx_w(LH);
    localparam int unsigned NW    = idx_w(LX + LH - 1);
    localparam int unsigned LastN = LX + LH - 2;

    state_e state_q, state_d;

    logic [NW-1:0]           n_q, n_d;
    logic [KW-1:0]           k_q, k_d;
    logic [KW-1:0]           khi_q, khi_d;
    logic signed [DW-1:0]    x_q [LX];
    logic signed [DW-1:0]    h_q [LH];
    logic [HW-1:0]           h_idx;
    logic signed [DW-1:0]    op_a, op_b;
    logic                    x_wr, h_wr, skip;
    logic                    acc_clr, acc_add;
    logic signed [ACC_W-1:0] addend, acc;
    logic                    mul_start, busy, done, y_valid;

    assign h_idx = HW'(int'(n_q) - int'(k_q));
    assign op_a  = x_q[k_q];
    assign op_b  = h_q[h_idx];

`ifdef ZERO_SKIP_EN
    assign skip = (op_a == '0) || (op_b == '0);
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.start) state_d = StSetup;
            StSetup: state_d = StIssue;
            StIssue: state_d = skip ? StNext : StWait;
            StWait:  if (bus.mul_done) state_d = StNext;
            StNext:  state_d = (k_q < khi_q) ? StIssue : StOut;
            StOut: begin
                if (bus.y_ready) state_d = (int'(n_q) < int'(LastN)) ? StSetup : StFin;
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mul_start = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        y_valid   = 1'b0;
        case (state_q)
            StIdle:  busy = 1'b0;
            StIssue: mul_start = !skip;
            StOut:   y_valid = 1'b1;
            StFin: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Loads only while idle; load_x wins when both strobes are high.
    always_comb begin
        x_wr = 1'b0;
        h_wr = 1'b0;
        if (state_q == StIdle) begin
            if (bus.load_x) begin
                x_wr = int'(bus.load_idx) < int'(LX);
            end else if (bus.load_h) begin
                h_wr = int'(bus.load_idx) < int'(LH);
            end
        end
    end

    always_comb begin
        n_d   = n_q;
        k_d   = k_q;
        khi_d = khi_q;
        case (state_q)
            StIdle: if (bus.start) n_d = '0;
            StSetup: begin
                k_d   = (int'(n_q) >= int'(LH) - 1) ? KW'(int'(n_q) - int'(LH) + 1) : '0;
                khi_d = (int'(n_q) < int'(LX) - 1) ? KW'(n_q) : KW'(LX - 1);
            end
            StNext: if (k_q < khi_q) k_d = k_q + KW'(1);
            StOut: begin
                if (bus.y_ready && (int'(n_q) < int'(LastN))) n_d = n_q + NW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q   <= '0;
            k_q   <= '0;
            khi_q <= '0;
            for (int i = 0; i < int'(LX); i++) x_q[i] <= '0;
            for (int i = 0; i < int'(LH); i++) h_q[i] <= '0;
        end else begin
            n_q   <= n_d;
            k_q   <= k_d;
            khi_q <= khi_d;
            if (x_wr) x_q[KW'(bus.load_idx)] <= bus.load_data;
            if (h_wr) h_q[HW'(bus.load_idx)] <= bus.load_data;
        end
    end

    assign acc_clr = (state_q == StSetup);
    assign acc_add = (state_q == StWait) && bus.mul_done;
    assign addend  = ACC_W'(sext({{(64 - PW){1'b0}}, bus.mul_prod}, PW));

    conv_acc #(
        .ACC_W(ACC_W)
    ) u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (acc_clr),
        .add_i   (acc_add),
        .addend_i(addend),
        .acc_o   (acc)
    );

    assign bus.mul_start = mul_start;
    assign bus.mul_a     = op_a;
    assign bus.mul_b     = op_b;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.y_valid   = y_valid;
    assign bus.y_data    = acc;
    assign bus.y_idx     = n_q;

endmodule
